// File: rtl/split_arbiter_pkg.sv
// rtl/split_arbiter_pkg.sv - shared state encodings and constant helpers for split_arbiter
// Package split_arb_defs:
//   state_e : IDLE=0, BURST=1, PAD=2 (PAD used only with SPLIT_ARB_TIMEOUT_EN)
//   clog2   : constant ceil(log2) used for parameter checks
package split_arb_defs;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_PAD   = 2'd2
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/split_arbiter_if.sv
// rtl/split_arbiter_if.sv - source-side and split-side bus of split_arbiter
// Signals:
//   in_data   WIDTH*N_SOURCES  source s at [WIDTH*s +: WIDTH]
//   in_nd     N_SOURCES        per-source valid
//   in_ready  N_SOURCES        per-source ready
//   out_data  WIDTH            word to split
//   out_nd    1                strobe to split
//   out_src   LOG_N_SOURCES    source id of out_data
//   out_first 1                beat 0 of a burst
//   out_pad   1                padding word marker
// Modports: slave = arbiter side, master = sources/sink side.
interface split_arbiter_if #(
   parameter int N_SOURCES     = 4,
   parameter int LOG_N_SOURCES = 2,
   parameter int WIDTH         = 32
);

   logic [WIDTH*N_SOURCES-1:0] in_data;
   logic [N_SOURCES-1:0]       in_nd;
   logic [N_SOURCES-1:0]       in_ready;
   logic [WIDTH-1:0]           out_data;
   logic                       out_nd;
   logic [LOG_N_SOURCES-1:0]   out_src;
   logic                       out_first;
   logic                       out_pad;

   modport slave (
      input  in_data, in_nd,
      output in_ready, out_data, out_nd, out_src, out_first, out_pad
   );

   modport master (
      output in_data, in_nd,
      input  in_ready, out_data, out_nd, out_src, out_first, out_pad
   );

endinterface

// File: rtl/split_arbiter_rr_pick.sv
// rtl/split_arbiter_rr_pick.sv - combinational round-robin priority picker
// Ports:
//   req   in  N_SOURCES      request vector
//   last  in  LOG_N_SOURCES  previously granted index
//   found out 1              any request set
//   idx   out LOG_N_SOURCES  first set request scanning upward from last+1 (mod N_SOURCES)
module rr_pick #(
   parameter int N_SOURCES     = 4,
   parameter int LOG_N_SOURCES = 2
) (
   input  logic [N_SOURCES-1:0]     req,
   input  logic [LOG_N_SOURCES-1:0] last,
   output logic                     found,
   output logic [LOG_N_SOURCES-1:0] idx
);

   // Offset 1..N so that last itself is considered only after every other source.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= N_SOURCES; i++) begin
         if (!found && req[(int'(last) + i) % N_SOURCES]) begin
            found = 1'b1;
            idx   = LOG_N_SOURCES'((int'(last) + i) % N_SOURCES);
         end
      end
   end

endmodule

// File: rtl/split_arbiter.sv
// rtl/split_arbiter.sv - packet-granular round-robin arbiter feeding a split deserializer
// Grants one source for BURST_LEN words, forwards them as one registered data/nd stream
// tagged with source id and burst-start flag. One IDLE arbitration cycle between bursts.
// Ports:
//   clk    in  clock
//   rst_n  in  synchronous active-low reset (shared with downstream split)
//   bus    split_arbiter_if.slave (in_data/in_nd/in_ready, out_data/out_nd/out_src/out_first/out_pad)
// Optional: define SPLIT_ARB_TIMEOUT_EN to pad out a burst stalled for TIMEOUT_CYCLES cycles.
module split_arbiter
   import split_arb_defs::*;
#(
   parameter int N_SOURCES      = 4,
   parameter int LOG_N_SOURCES  = 2,
   parameter int WIDTH          = 32,
   parameter int BURST_LEN      = 2,
   parameter int LOG_BURST_LEN  = 1,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int LOG_TIMEOUT    = 5
) (
   input logic           clk,
   input logic           rst_n,
   split_arbiter_if.slave bus
);

   if (LOG_N_SOURCES < clog2(N_SOURCES) || BURST_LEN < 1 ||
       (1 << LOG_BURST_LEN) < BURST_LEN || (1 << LOG_TIMEOUT) <= TIMEOUT_CYCLES) begin : g_bad_params
      $error("split_arbiter: inconsistent parameters");
   end

   localparam logic [LOG_BURST_LEN-1:0] LAST_BEAT = LOG_BURST_LEN'(BURST_LEN - 1);

   state_e                   state_q, state_d;
   logic [LOG_N_SOURCES-1:0] grant_q, grant_d;
   logic [LOG_N_SOURCES-1:0] last_q, last_d;
   logic [LOG_BURST_LEN-1:0] beat_q, beat_d;
   logic [WIDTH-1:0]         out_data_q, out_data_d;
   logic                     out_nd_q, out_nd_d;
   logic [LOG_N_SOURCES-1:0] out_src_q, out_src_d;
   logic                     out_first_q, out_first_d;

   logic                     pick_found;
   logic [LOG_N_SOURCES-1:0] pick_idx;
   logic [N_SOURCES-1:0]     ready_oh;
   logic                     xfer;
   logic [WIDTH-1:0]         grant_word;

   rr_pick #(
      .N_SOURCES     (N_SOURCES),
      .LOG_N_SOURCES (LOG_N_SOURCES)
   ) u_pick (
      .req   (bus.in_nd),
      .last  (last_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Ready comes purely from registered state so sources never see a comb loop through in_nd.
   always_comb begin
      ready_oh = '0;
      if (state_q == ST_BURST) ready_oh[grant_q] = 1'b1;
   end

   assign bus.in_ready = ready_oh;
   assign xfer         = (state_q == ST_BURST) && bus.in_nd[grant_q];
   assign grant_word   = bus.in_data[int'(grant_q)*WIDTH +: WIDTH];

`ifdef SPLIT_ARB_TIMEOUT_EN
   logic [LOG_TIMEOUT-1:0] stall_q, stall_d;
   logic                   out_pad_q, out_pad_d;
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      beat_d      = beat_q;
      out_data_d  = out_data_q;
      out_nd_d    = 1'b0;
      out_src_d   = out_src_q;
      out_first_d = out_first_q;
`ifdef SPLIT_ARB_TIMEOUT_EN
      stall_d     = stall_q;
      out_pad_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               beat_d  = '0;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            if (xfer) begin
               out_data_d  = grant_word;
               out_nd_d    = 1'b1;
               out_src_d   = grant_q;
               out_first_d = (beat_q == '0);
               beat_d      = beat_q + LOG_BURST_LEN'(1);
`ifdef SPLIT_ARB_TIMEOUT_EN
               stall_d     = '0;
`endif
               if (beat_q == LAST_BEAT) begin
                  last_d  = grant_q;
                  beat_d  = '0;
                  state_d = ST_IDLE;
               end
            end else begin
`ifdef SPLIT_ARB_TIMEOUT_EN
               stall_d = stall_q + LOG_TIMEOUT'(1);
               // Entered even at beat 0 so every grant always yields exactly BURST_LEN words.
               if (stall_q == LOG_TIMEOUT'(TIMEOUT_CYCLES - 1)) state_d = ST_PAD;
`endif
            end
         end
`ifdef SPLIT_ARB_TIMEOUT_EN
         ST_PAD: begin
            out_data_d  = '0;
            out_nd_d    = 1'b1;
            out_pad_d   = 1'b1;
            out_src_d   = grant_q;
            out_first_d = (beat_q == '0);
            beat_d      = beat_q + LOG_BURST_LEN'(1);
            if (beat_q == LAST_BEAT) begin
               last_d  = grant_q;
               beat_d  = '0;
               stall_d = '0;
               state_d = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         last_q      <= LOG_N_SOURCES'(N_SOURCES - 1);
         beat_q      <= '0;
         out_data_q  <= '0;
         out_nd_q    <= 1'b0;
         out_src_q   <= '0;
         out_first_q <= 1'b0;
`ifdef SPLIT_ARB_TIMEOUT_EN
         stall_q     <= '0;
         out_pad_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         beat_q      <= beat_d;
         out_data_q  <= out_data_d;
         out_nd_q    <= out_nd_d;
         out_src_q   <= out_src_d;
         out_first_q <= out_first_d;
`ifdef SPLIT_ARB_TIMEOUT_EN
         stall_q     <= stall_d;
         out_pad_q   <= out_pad_d;
`endif
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_nd    = out_nd_q;
   assign bus.out_src   = out_src_q;
   assign bus.out_first = out_first_q;
`ifdef SPLIT_ARB_TIMEOUT_EN
   assign bus.out_pad   = out_pad_q;
`else
   assign bus.out_pad   = 1'b0;
`endif

endmodule

// File: tb/tb_split_arbiter.sv
// tb/tb_split_arbiter.sv - randomized self-checking bench for split_arbiter against a transaction model
module tb_split_arbiter;

   localparam int N   = 4;
   localparam int LN  = 2;
   localparam int W   = 32;
   localparam int BL  = 2;
   localparam int LBL = 1;
`ifdef SPLIT_ARB_TIMEOUT_EN
   localparam int TO  = 4;
`else
   localparam int TO  = 16;
`endif
   localparam int LTO = 5;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   split_arbiter_if #(.N_SOURCES(N), .LOG_N_SOURCES(LN), .WIDTH(W)) bus ();

   split_arbiter #(
      .N_SOURCES      (N),
      .LOG_N_SOURCES  (LN),
      .WIDTH          (W),
      .BURST_LEN      (BL),
      .LOG_BURST_LEN  (LBL),
      .TIMEOUT_CYCLES (TO),
      .LOG_TIMEOUT    (LTO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Transaction-level model: owner<0 means arbitrating, otherwise owner has sent 'sent' words.
   int m_owner = -1;
   int m_last  = N - 1;
   int m_sent  = 0;
   int m_stall = 0;
   bit m_pad   = 0;

   task automatic model_reset();
      m_owner = -1;
      m_last  = N - 1;
      m_sent  = 0;
      m_stall = 0;
      m_pad   = 0;
   endtask

   task automatic step(input logic [N-1:0] nd, input logic rst);
      logic [W*N-1:0] data;
      logic [N-1:0]   exp_ready;
      logic [W-1:0]   e_data;
      logic [LN-1:0]  e_src;
      logic           e_nd, e_first, e_pad, full;
      for (int s = 0; s < N; s++) data[s*W +: W] = $urandom();
      bus.in_data = data;
      bus.in_nd   = nd;
      rst_n       = rst;
      exp_ready   = (m_owner >= 0 && !m_pad) ? (N'(1) << m_owner) : '0;
      #1;
      check("in_ready", bus.in_ready, exp_ready);
      @(posedge clk);
      #1;
      e_nd = 0; e_data = '0; e_src = '0; e_first = 0; e_pad = 0; full = 0;
      if (!rst) begin
         model_reset();
         full = 1;
      end else if (m_owner < 0) begin
         for (int i = 1; i <= N; i++)
            if (m_owner < 0 && nd[(m_last + i) % N]) begin
               m_owner = (m_last + i) % N;
               m_sent  = 0;
            end
      end else if (m_pad) begin
         e_nd = 1; e_pad = 1; e_src = LN'(m_owner); e_first = (m_sent == 0); full = 1;
         m_sent++;
         if (m_sent == BL) begin
            m_last = m_owner; m_owner = -1; m_pad = 0; m_stall = 0;
         end
      end else if (nd[m_owner]) begin
         e_nd = 1; e_data = data[m_owner*W +: W]; e_src = LN'(m_owner);
         e_first = (m_sent == 0); full = 1;
         m_sent++;
         m_stall = 0;
         if (m_sent == BL) begin
            m_last = m_owner; m_owner = -1;
         end
      end else begin
`ifdef SPLIT_ARB_TIMEOUT_EN
         m_stall++;
         if (m_stall == TO) m_pad = 1;
`endif
      end
      check("out_nd", bus.out_nd, e_nd);
      if (full) begin
         check("out_data", bus.out_data, e_data);
         check("out_src", bus.out_src, e_src);
         check("out_first", bus.out_first, e_first);
         check("out_pad", bus.out_pad, e_pad);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.in_nd   = '0;
      bus.in_data = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check("reset_out_nd", bus.out_nd, 1'b0);
      check("reset_out_data", bus.out_data, '0);
      check("reset_out_src", bus.out_src, '0);
      check("reset_out_first", bus.out_first, 1'b0);
      check("reset_out_pad", bus.out_pad, 1'b0);
      check("reset_in_ready", bus.in_ready, '0);

      // Single source continuously valid: bursts separated by one dead cycle.
      repeat (12) step(4'b0001, 1'b1);
      // All sources valid: rotation 0,1,2,3,...
      repeat (24) step(4'b1111, 1'b1);
      // Mid-burst stall of source 0 while others wait; exercises timeout when enabled.
      step(4'b0000, 1'b0);
      step(4'b0001, 1'b1);
      step(4'b0001, 1'b1);
      repeat (8) step(4'b1110, 1'b1);
      repeat (8) step(4'b1111, 1'b1);
      // Mid-burst reset with source 2 owning the bus, then priority restarts at 0.
      step(4'b0000, 1'b0);
      step(4'b0100, 1'b1);
      step(4'b0100, 1'b1);
      step(4'b0101, 1'b0);
      repeat (6) step(4'b0101, 1'b1);
      // Sparse and dense random requests.
      repeat (300) step(N'($urandom()), 1'b1);
      repeat (200) step(N'($urandom()) | N'($urandom()), 1'b1);
      // Random traffic with occasional resets.
      repeat (300) step(N'($urandom()), ($urandom_range(0, 19) != 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
